alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX pipeline stage driving the ALU operand/control interface. Decodes opcode/funct into a 4-bit ALU code.
//  Selects and forwards operands, registers them for the EX stage, and detects load-use hazards.
//  Sits between the register file/decoder and the combinational ALU; the ALU result returns here for EX->ID forwarding.
// PARAMETERS
//  XLEN   32  datapath width
//  REG_W  5   register index width
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  reset          in   1      synchronous, active-high reset
//  id_valid       in   1      ID holds a real instruction
//  id_opcode      in   6      instr[31:26]
//  id_funct       in   6      instr[5:0]
//  id_shamt       in   5      instr[10:6]
//  id_rs,id_rt,id_rd in REG_W source/dest indices
//  id_imm16       in   16     instr[15:0]
//  id_rs_data,id_rt_data in XLEN regfile read data
//  alu_result     in   XLEN   ALU output for the instruction now in EX
//  mem_regwrite,mem_rd,mem_result in 1/REG_W/XLEN  MEM-stage writeback candidate
//  wb_regwrite,wb_rd,wb_result    in 1/REG_W/XLEN  WB-stage writeback candidate
//  flush          in   1      kill the ID instruction (branch taken)
//  ex_stall       in   1      downstream stall; hold EX registers
//  hazard_stall   out  1      comb; load-use detected, freeze PC and IF/ID
//  ex_valid       out  1      EX register holds a real instruction
//  Aluctl         out  4      ALU code: 0 AND,1 OR,2 ADD,3 SLL,6 SUB,7 SLT,12 NOR
//  shamt          out  5      shift amount
//  input1,input2  out  XLEN   ALU operands
//  ex_store_data  out  XLEN   forwarded rt value for sw
//  ex_dest        out  REG_W  write-back register
//  ex_regwrite,ex_memread,ex_memwrite out 1  control for later stages
//  ex_illegal     out  1      one-cycle flag: unsupported opcode/funct issued as bubble
// BEHAVIOUR
//  Reset: all outputs 0 (ex_valid=0, Aluctl=0, operands 0, ex_dest=0) on the first edge with reset=1.
//  Latency: one cycle ID->EX. EX register loads when !ex_stall; ex_stall has priority over everything but reset.
//  Decode: R-type(0x00) funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT, 00 SLL;
//   addi/addiu(08/09) ADD sext; slti(0A) SLT sext; andi(0C) AND zext; ori(0D) OR zext;
//   lw(23) ADD sext,memread; sw(2B) ADD sext,memwrite,no regwrite; beq(04) SUB, no regwrite.
//  Dest: rd for R-type, rt for I-type. Unknown code -> bubble, ex_illegal=1 for one cycle.
//  SLL: input1 = forwarded rt, shamt = id_shamt; otherwise shamt=0.
//  Forwarding per source (rs, rt), index 0 never forwarded, priority EX > MEM > WB > regfile:
//   EX match (ex_valid & ex_regwrite & !ex_memread & ex_dest==src) -> alu_result.
//  Load-use: ex_valid & ex_memread & ex_dest!=0 & ex_dest matches a used source -> hazard_stall=1, bubble into EX.
//  Bubble = ex_valid=0, all write/mem enables 0; operands are don't-care but driven 0.
//  flush: inserts bubble this edge, suppresses ex_illegal; flush with hazard_stall -> bubble, hazard_stall still 1.
//  id_valid=0 -> bubble. ex_illegal clears on any subsequent load. Reset mid-stall -> clean bubble state.
//  Arithmetic: sext = {{16{imm[15]}},imm}; zext = {16'b0,imm}.
// STRUCTURE
//  alu_pkg: ALU code constants (ALU_AND..ALU_NOR), opcode/funct localparams, decoded-control struct.
//  Sub-module alu_ctl_decode: combinational opcode/funct -> {Aluctl, imm_sel, regwrite, memread, memwrite, dst_sel, legal}.
//  Top: forwarding muxes, hazard compare, EX pipeline register.
// TESTING
//  add r3,r1,r2 (r1=5,r2=7) -> next edge Aluctl=2, input1=5, input2=7, ex_dest=3, ex_regwrite=1.
//  ori r4,r1,0x8001 -> input2=0x00008001, Aluctl=1; addi imm 0x8001 -> input2=0xFFFF8001, Aluctl=2.
//  add r5,r3,r3 after add r3 (alu_result=12) -> both operands 12; same with r0 dest -> regfile value.
//  lw r6 then add r7,r6,r1 -> hazard_stall=1 one cycle, ex_valid=0 bubble, then input1=mem_result.
//  funct 0x3F R-type -> ex_valid=0, ex_illegal=1 one cycle; with flush -> ex_illegal=0.
//  reset asserted during ex_stall with valid EX -> next edge all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ID/EX ALU issue stage.
//  - ALU operation codes seen by the combinational ALU
//  - opcode / funct encodings of the supported instruction subset
//  - decoded-control struct produced by alu_ctl_decode
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Second ALU operand source
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,  // forwarded rt
    IMM_SEXT = 2'd1,  // sign-extended imm16
    IMM_ZEXT = 2'd2   // zero-extended imm16
  } imm_sel_e;

  // Write-back register field
  typedef enum logic {
    DST_RT = 1'b0,
    DST_RD = 1'b1
  } dst_sel_e;

  typedef struct packed {
    logic [3:0] aluctl;
    imm_sel_e   imm_sel;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    dst_sel_e   dst_sel;
    logic       use_rs;    // rs is a real source (for load-use detection)
    logic       use_rt;    // rt is a real source
    logic       is_sll;    // shift: operand 1 comes from rt
    logic       legal;
  } dec_ctl_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational opcode/funct decoder.
// Ports:
//  opcode  in  6          instr[31:26]
//  funct   in  6          instr[5:0]
//  ctl     out dec_ctl_t  ALU code, operand/dest selects, memory and write-back
//                         enables, source usage and legality
// Unsupported encodings return legal=0 with every enable cleared.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_ctl_t   ctl
);

  always_comb begin
    ctl          = '0;
    ctl.imm_sel  = IMM_NONE;
    ctl.dst_sel  = DST_RT;
    ctl.legal    = 1'b1;
    ctl.regwrite = 1'b1;
    ctl.use_rs   = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        ctl.dst_sel = DST_RD;
        ctl.use_rt  = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctl.aluctl = ALU_ADD;
          FN_SUB, FN_SUBU: ctl.aluctl = ALU_SUB;
          FN_AND:          ctl.aluctl = ALU_AND;
          FN_OR:           ctl.aluctl = ALU_OR;
          FN_NOR:          ctl.aluctl = ALU_NOR;
          FN_SLT:          ctl.aluctl = ALU_SLT;
          FN_SLL: begin
            ctl.aluctl = ALU_SLL;
            ctl.is_sll = 1'b1;
            ctl.use_rs = 1'b0;
          end
          default:         ctl.legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctl.aluctl  = ALU_ADD;
        ctl.imm_sel = IMM_SEXT;
      end
      OP_SLTI: begin
        ctl.aluctl  = ALU_SLT;
        ctl.imm_sel = IMM_SEXT;
      end
      OP_ANDI: begin
        ctl.aluctl  = ALU_AND;
        ctl.imm_sel = IMM_ZEXT;
      end
      OP_ORI: begin
        ctl.aluctl  = ALU_OR;
        ctl.imm_sel = IMM_ZEXT;
      end
      OP_LW: begin
        ctl.aluctl  = ALU_ADD;
        ctl.imm_sel = IMM_SEXT;
        ctl.memread = 1'b1;
      end
      OP_SW: begin
        ctl.aluctl   = ALU_ADD;
        ctl.imm_sel  = IMM_SEXT;
        ctl.memwrite = 1'b1;
        ctl.regwrite = 1'b0;
        ctl.use_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctl.aluctl   = ALU_SUB;
        ctl.regwrite = 1'b0;
        ctl.use_rt   = 1'b1;
      end
      default: ctl.legal = 1'b0;
    endcase

    // Illegal encodings behave as a bubble: no enables, no sources.
    if (!ctl.legal) begin
      ctl.regwrite = 1'b0;
      ctl.use_rs   = 1'b0;
      ctl.use_rt   = 1'b0;
      ctl.aluctl   = ALU_AND;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage in front of the combinational ALU.
// Decodes the ID instruction, forwards rs/rt (EX > MEM > WB > regfile),
// detects load-use hazards and registers operands/control for EX.
// Ports:
//  clk, reset                      clock, synchronous active-high reset
//  id_*                            instruction fields and regfile read data
//  alu_result                      ALU output of the instruction now in EX
//  mem_regwrite/mem_rd/mem_result  MEM-stage writeback candidate
//  wb_regwrite/wb_rd/wb_result     WB-stage writeback candidate
//  flush                           kill the ID instruction
//  ex_stall                        hold the EX register
//  hazard_stall                    comb: load-use, freeze PC and IF/ID
//  ex_valid, Aluctl, shamt, input1, input2, ex_store_data, ex_dest,
//  ex_regwrite, ex_memread, ex_memwrite, ex_illegal   EX register outputs
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [4:0]       id_shamt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic [15:0]      id_imm16,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [3:0]       Aluctl,
  output logic [4:0]       shamt,
  output logic [XLEN-1:0]  input1,
  output logic [XLEN-1:0]  input2,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [REG_W-1:0] ex_dest,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_illegal
);

  dec_ctl_t dec;

  alu_ctl_decode u_decode (
    .opcode (id_opcode),
    .funct  (id_funct),
    .ctl    (dec)
  );

  // EX pipeline register
  logic             ex_valid_reg,    ex_valid_next;
  logic [3:0]       aluctl_reg,      aluctl_next;
  logic [4:0]       shamt_reg,       shamt_next;
  logic [XLEN-1:0]  input1_reg,      input1_next;
  logic [XLEN-1:0]  input2_reg,      input2_next;
  logic [XLEN-1:0]  store_data_reg,  store_data_next;
  logic [REG_W-1:0] ex_dest_reg,     ex_dest_next;
  logic             ex_regwrite_reg, ex_regwrite_next;
  logic             ex_memread_reg,  ex_memread_next;
  logic             ex_memwrite_reg, ex_memwrite_next;
  logic             ex_illegal_reg,  ex_illegal_next;

  // Per-source forwarding and hazard compare; slot 0 = rs, slot 1 = rt.
  logic [1:0][REG_W-1:0] src_idx;
  logic [1:0][XLEN-1:0]  src_rf;
  logic [1:0][XLEN-1:0]  src_fwd;
  logic [1:0]            src_used;
  logic [1:0]            src_hit;

  assign src_idx  = {id_rt, id_rs};
  assign src_rf   = {id_rt_data, id_rs_data};
  assign src_used = {dec.use_rt, dec.use_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic nz, ex_fwd, mem_fwd, wb_fwd;
      // r0 is hard-wired zero, so it is never taken from a later stage.
      assign nz      = |src_idx[gi];
      // A load in EX has no result yet; that case is the load-use stall.
      assign ex_fwd  = nz & ex_valid_reg & ex_regwrite_reg & ~ex_memread_reg &
                       (ex_dest_reg == src_idx[gi]);
      assign mem_fwd = nz & mem_regwrite & (mem_rd == src_idx[gi]);
      assign wb_fwd  = nz & wb_regwrite & (wb_rd == src_idx[gi]);
      assign src_fwd[gi] = ex_fwd  ? alu_result :
                           mem_fwd ? mem_result :
                           wb_fwd  ? wb_result  : src_rf[gi];
      assign src_hit[gi] = id_valid & src_used[gi] & ex_valid_reg & ex_memread_reg &
                           (|ex_dest_reg) & (ex_dest_reg == src_idx[gi]);
    end
  endgenerate

  // flush does not mask the stall: the front end must still hold.
  assign hazard_stall = |src_hit;

  logic [XLEN-1:0] imm_ext;
  logic            issue;

  assign imm_ext = (dec.imm_sel == IMM_ZEXT) ? {{(XLEN-16){1'b0}}, id_imm16}
                                             : {{(XLEN-16){id_imm16[15]}}, id_imm16};
  assign issue   = id_valid & ~flush & ~hazard_stall & dec.legal;

  always_comb begin
    ex_valid_next    = 1'b0;
    aluctl_next      = '0;
    shamt_next       = '0;
    input1_next      = '0;
    input2_next      = '0;
    store_data_next  = '0;
    ex_dest_next     = '0;
    ex_regwrite_next = 1'b0;
    ex_memread_next  = 1'b0;
    ex_memwrite_next = 1'b0;
    // Illegal encodings are reported unless the slot was flushed anyway.
    ex_illegal_next  = id_valid & ~flush & ~dec.legal;
    if (issue) begin
      ex_valid_next    = 1'b1;
      aluctl_next      = dec.aluctl;
      shamt_next       = dec.is_sll ? id_shamt : 5'd0;
      // Shifts operate on rt; operand 2 then simply carries rt as well.
      input1_next      = dec.is_sll ? src_fwd[1] : src_fwd[0];
      input2_next      = (dec.imm_sel == IMM_NONE) ? src_fwd[1] : imm_ext;
      store_data_next  = src_fwd[1];
      ex_dest_next     = (dec.dst_sel == DST_RD) ? id_rd : id_rt;
      ex_regwrite_next = dec.regwrite;
      ex_memread_next  = dec.memread;
      ex_memwrite_next = dec.memwrite;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg    <= 1'b0;
      aluctl_reg      <= '0;
      shamt_reg       <= '0;
      input1_reg      <= '0;
      input2_reg      <= '0;
      store_data_reg  <= '0;
      ex_dest_reg     <= '0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
      ex_illegal_reg  <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid_reg    <= ex_valid_next;
      aluctl_reg      <= aluctl_next;
      shamt_reg       <= shamt_next;
      input1_reg      <= input1_next;
      input2_reg      <= input2_next;
      store_data_reg  <= store_data_next;
      ex_dest_reg     <= ex_dest_next;
      ex_regwrite_reg <= ex_regwrite_next;
      ex_memread_reg  <= ex_memread_next;
      ex_memwrite_reg <= ex_memwrite_next;
      ex_illegal_reg  <= ex_illegal_next;
    end
  end

  assign ex_valid      = ex_valid_reg;
  assign Aluctl        = aluctl_reg;
  assign shamt         = shamt_reg;
  assign input1        = input1_reg;
  assign input2        = input2_reg;
  assign ex_store_data = store_data_reg;
  assign ex_dest       = ex_dest_reg;
  assign ex_regwrite   = ex_regwrite_reg;
  assign ex_memread    = ex_memread_reg;
  assign ex_memwrite   = ex_memwrite_reg;
  assign ex_illegal    = ex_illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver computes the expected EX
// contents from an instruction-level model and queues them; the monitor pops
// one entry after every rising edge and compares it with the EX outputs.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, flush, ex_stall;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [31:0] id_rs_data, id_rt_data, alu_result;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
  logic [3:0]  Aluctl;
  logic [4:0]  shamt, ex_dest;
  logic [31:0] input1, input2, ex_store_data;

  alu_issue_stage #(.XLEN(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_imm16(id_imm16), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .alu_result(alu_result),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .ex_stall(ex_stall), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .Aluctl(Aluctl), .shamt(shamt), .input1(input1),
    .input2(input2), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
  );

  typedef struct {
    bit        valid;
    bit [3:0]  code;
    bit [4:0]  sh;
    bit [31:0] in1, in2, store;
    bit [4:0]  dest;
    bit        rw, mr, mw, ill;
  } ex_t;

  ex_t       mex;          // model of what EX holds now
  ex_t       expq[$];
  int        checks = 0;
  int        passed = 0;
  int        cycle  = 0;
  bit [31:0] regs[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %h want %h", name, cycle, act, exp);
  endtask

  // Instruction-set view of the supported subset.
  function automatic void ref_decode(input bit [5:0] op, input bit [5:0] fn,
      output bit legal, output bit [3:0] code, output int imm_kind,
      output bit rw, output bit mr, output bit mw, output bit dst_rd,
      output bit urs, output bit urt, output bit sll);
    legal = 1; code = 0; imm_kind = 0; rw = 1; mr = 0; mw = 0;
    dst_rd = 0; urs = 1; urt = 0; sll = 0;
    case (op)
      6'h00: begin
        dst_rd = 1; urt = 1;
        case (fn)
          6'h20, 6'h21: code = 2;
          6'h22, 6'h23: code = 6;
          6'h24: code = 0;
          6'h25: code = 1;
          6'h27: code = 12;
          6'h2A: code = 7;
          6'h00: begin code = 3; sll = 1; urs = 0; end
          default: legal = 0;
        endcase
      end
      6'h08, 6'h09: begin code = 2; imm_kind = 1; end
      6'h0A: begin code = 7; imm_kind = 1; end
      6'h0C: begin code = 0; imm_kind = 2; end
      6'h0D: begin code = 1; imm_kind = 2; end
      6'h23: begin code = 2; imm_kind = 1; mr = 1; end
      6'h2B: begin code = 2; imm_kind = 1; mw = 1; rw = 0; urt = 1; end
      6'h04: begin code = 6; rw = 0; urt = 1; end
      default: legal = 0;
    endcase
    if (!legal) begin urs = 0; urt = 0; end
  endfunction

  // Value of a source register as seen by the instruction in ID.
  function automatic bit [31:0] src_val(input bit [4:0] idx, input bit [31:0] rf);
    if (idx == 0) return rf;
    if (mex.valid && mex.rw && !mex.mr && mex.dest == idx) return alu_result;
    if (mem_regwrite && mem_rd == idx) return mem_result;
    if (wb_regwrite && wb_rd == idx) return wb_result;
    return rf;
  endfunction

  // Evaluate the current inputs, check the stall, queue the next EX state,
  // then advance to the next falling edge.
  task automatic step();
    bit legal, rw, mr, mw, dst_rd, urs, urt, sll, hz;
    bit [3:0] code;
    int imm_kind;
    bit [31:0] a, b, immv;
    ex_t nxt;
    #1;
    ref_decode(id_opcode, id_funct, legal, code, imm_kind, rw, mr, mw, dst_rd, urs, urt, sll);
    hz = id_valid && mex.valid && mex.mr && mex.dest != 0 &&
         ((urs && id_rs == mex.dest) || (urt && id_rt == mex.dest));
    if (!reset) chk("hazard_stall", 32'(hazard_stall), 32'(hz));
    a = src_val(id_rs, id_rs_data);
    b = src_val(id_rt, id_rt_data);
    immv = (imm_kind == 2) ? {16'h0, id_imm16} : {{16{id_imm16[15]}}, id_imm16};
    nxt = '{default: 0};
    if (reset) nxt = '{default: 0};
    else if (ex_stall) nxt = mex;
    else if (id_valid && !flush && !hz && legal) begin
      nxt.valid = 1; nxt.code = code; nxt.sh = sll ? id_shamt : 5'd0;
      nxt.in1 = sll ? b : a;
      nxt.in2 = (imm_kind == 0) ? b : immv;
      nxt.store = b;
      nxt.dest = dst_rd ? id_rd : id_rt;
      nxt.rw = rw; nxt.mr = mr; nxt.mw = mw;
    end else begin
      nxt.ill = id_valid && !flush && !legal;
    end
    expq.push_back(nxt);
    mex = nxt;
    @(negedge clk);
    cycle++;
  endtask

  task automatic quiet();
    reset = 0; flush = 0; ex_stall = 0; id_valid = 1;
    mem_regwrite = 0; wb_regwrite = 0; mem_rd = 0; wb_rd = 0;
    mem_result = 32'hA5A5_0000; wb_result = 32'h5A5A_0000; alu_result = 32'hCCCC_0000;
  endtask

  task automatic instr(input bit [5:0] op, input bit [5:0] fn, input bit [4:0] rs,
      input bit [4:0] rt, input bit [4:0] rd, input bit [4:0] sh, input bit [15:0] imm);
    id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_shamt = sh; id_imm16 = imm;
    id_rs_data = regs[rs]; id_rt_data = regs[rt];
  endtask

  // Monitor: one expected EX state per rising edge.
  initial begin
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ex_valid",      32'(ex_valid),    32'(e.valid));
        chk("Aluctl",        32'(Aluctl),      32'(e.code));
        chk("shamt",         32'(shamt),       32'(e.sh));
        chk("input1",        input1,           e.in1);
        chk("input2",        input2,           e.in2);
        chk("ex_store_data", ex_store_data,    e.store);
        chk("ex_dest",       32'(ex_dest),     32'(e.dest));
        chk("ex_regwrite",   32'(ex_regwrite), 32'(e.rw));
        chk("ex_memread",    32'(ex_memread),  32'(e.mr));
        chk("ex_memwrite",   32'(ex_memwrite), 32'(e.mw));
        chk("ex_illegal",    32'(ex_illegal),  32'(e.ill));
      end
    end
  end

  initial begin
    bit [5:0] ops[10];
    bit [5:0] fns[10];
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
    foreach (regs[i]) regs[i] = 32'(i) * 32'h0101_0101;
    regs[0] = 0; regs[1] = 5; regs[2] = 7;
    mex = '{default: 0};
    quiet();
    instr(6'h00, 6'h20, 1, 2, 3, 0, 0);
    reset = 1;
    @(negedge clk);
    step(); step();
    reset = 0;

    instr(6'h00, 6'h20, 1, 2, 3, 0, 0); step();                         // add r3,r1,r2
    alu_result = 12; instr(6'h00, 6'h20, 3, 3, 5, 0, 0); step();       // add r5,r3,r3
    instr(6'h00, 6'h20, 1, 2, 0, 0, 0); step();                         // add r0,r1,r2
    alu_result = 12; instr(6'h00, 6'h20, 0, 0, 5, 0, 0); step();       // add r5,r0,r0
    instr(6'h0D, 6'h00, 1, 4, 0, 0, 16'h8001); step();                  // ori
    instr(6'h08, 6'h00, 1, 4, 0, 0, 16'h8001); step();                  // addi
    instr(6'h23, 6'h00, 1, 6, 0, 0, 16'h0010); step();                  // lw r6
    instr(6'h00, 6'h20, 6, 1, 7, 0, 0); step();                         // add r7,r6,r1 stalls
    mem_regwrite = 1; mem_rd = 6; mem_result = 32'hDEAD_0001; step();   // re-issued
    quiet();
    instr(6'h00, 6'h3F, 1, 2, 9, 0, 0); step();                         // illegal funct
    flush = 1; step(); flush = 0;                                       // illegal + flush
    instr(6'h00, 6'h00, 0, 2, 8, 4, 0); step();                         // sll r8,r2,4
    instr(6'h2B, 6'h00, 1, 2, 0, 0, 16'hFFFC); step();                  // sw
    instr(6'h04, 6'h00, 1, 2, 0, 0, 16'h0003); step();                  // beq
    instr(6'h23, 6'h00, 1, 6, 0, 0, 0); step();                         // lw r6
    instr(6'h00, 6'h20, 6, 1, 7, 0, 0); flush = 1; step(); flush = 0;   // flush + hazard
    instr(6'h00, 6'h20, 1, 2, 3, 0, 0); step();                         // valid EX
    ex_stall = 1; step();                                               // hold
    reset = 1; step(); reset = 0; ex_stall = 0;                         // reset mid-stall

    for (int n = 0; n < 400; n++) begin
      instr(ops[$urandom_range(9)], fns[$urandom_range(9)],
            5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            5'($urandom), 16'($urandom));
      if ($urandom_range(15) == 0) id_opcode = 6'h3E;
      if (id_rs != 0) id_rs_data = $urandom;
      if (id_rt != 0) id_rt_data = $urandom;
      id_valid     = ($urandom_range(9) != 0);
      flush        = ($urandom_range(9) == 0);
      ex_stall     = ($urandom_range(7) == 0);
      reset        = ($urandom_range(49) == 0);
      alu_result   = $urandom;
      mem_regwrite = 1'($urandom); mem_rd = 5'($urandom_range(7)); mem_result = $urandom;
      wb_regwrite  = 1'($urandom); wb_rd  = 5'($urandom_range(7)); wb_result  = $urandom;
      step();
    end
    quiet();
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", expq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
